async_fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one async_fifo write interface among NREQ requesters, all in the wclk domain.
- Grants whole packets (delimited by req_last), with a MAX_BURST cap for fairness.
- Drives winc/wdata directly into the FIFO.
- Uses wfull for per-beat backpressure and awfull to avoid starting new packets near full.

---
 rtl/async_fifo_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/async_fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbitration logic.
package async_fifo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int ARB_IDW(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder: nearest set bit of req at or
// above ptr, wrapping from N-1 back to 0.
module rr_pick
    import async_fifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = ARB_IDW(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    int pos_s;

    // Scan from the farthest offset down so the last hit kept is the nearest to ptr.
    always_comb begin
        vld   = 1'b0;
        idx   = '0;
        pos_s = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos_s = (int'(ptr) + k) % N;
            if (req[pos_s]) begin
                vld = 1'b1;
                idx = IW'(pos_s);
            end else begin
                vld = vld;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one async FIFO write port
// among NREQ wclk-domain requesters, with a MAX_BURST fairness cap.
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = ARB_IDW(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull,
    input  logic                  awfull,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_e     state_r, state_nxt_s;
    logic [IDW-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [IDW-1:0] gnt_q_r, gnt_q_nxt_s;
    logic [BCW-1:0] beat_cnt_r, beat_cnt_nxt_s;

    logic           cand_vld_s;
    logic [IDW-1:0] cand_idx_s;
    logic           gnt_vld_s;
    logic [IDW-1:0] gnt_idx_s;
    logic [IDW-1:0] id_s;
    logic           accept_s;
    logic           last_s;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .vld (cand_vld_s),
        .idx (cand_idx_s)
    );

    // Grant selection, beat acceptance and next-state computation.
    always_comb begin
        state_nxt_s    = state_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        gnt_q_nxt_s    = gnt_q_r;
        beat_cnt_nxt_s = beat_cnt_r;
        gnt_vld_s      = 1'b0;
        gnt_idx_s      = cand_idx_s;
        id_s           = '0;

        case (state_r)
            IDLE: begin
                gnt_vld_s = cand_vld_s & ~awfull & ~wfull;
                gnt_idx_s = cand_idx_s;
                id_s      = cand_vld_s ? cand_idx_s : '0;
            end
            BURST: begin
                // awfull is ignored here so an open packet drains into the remaining space.
                gnt_vld_s = 1'b1;
                gnt_idx_s = gnt_q_r;
                id_s      = gnt_q_r;
            end
            default: begin
                gnt_vld_s = 1'b0;
                gnt_idx_s = '0;
                id_s      = '0;
            end
        endcase

        accept_s = gnt_vld_s & ~wfull & req_valid[gnt_idx_s];
        last_s   = req_last[gnt_idx_s];

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (last_s || (MAX_BURST == 1)) begin
                        rr_ptr_nxt_s = next_ptr(gnt_idx_s);
                    end else begin
                        state_nxt_s    = BURST;
                        gnt_q_nxt_s    = gnt_idx_s;
                        beat_cnt_nxt_s = BCW'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (accept_s) begin
                    // Cap release may cut a packet; the owner resumes it on its next win.
                    if (last_s || (beat_cnt_r == BCW'(MAX_BURST - 1))) begin
                        state_nxt_s    = IDLE;
                        rr_ptr_nxt_s   = next_ptr(gnt_q_r);
                        beat_cnt_nxt_s = '0;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + BCW'(1);
                    end
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output drive; everything is forced quiet while reset is asserted.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        grant_id  = '0;
        busy      = 1'b0;
        if (wrst_n) begin
            if (gnt_vld_s && !wfull) begin
                req_ready[gnt_idx_s] = 1'b1;
            end else begin
                req_ready = '0;
            end
            winc     = accept_s;
            wdata    = gnt_vld_s ? req_data[gnt_idx_s*DSIZE +: DSIZE] : '0;
            grant_id = id_s;
            busy     = (state_r == BURST);
        end else begin
            req_ready = '0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            gnt_q_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            gnt_q_r    <= gnt_q_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter: directed packet scenarios
// plus randomized traffic against a behavioural arbitration model.
module tb_async_fifo_wr_arbiter;

    localparam int DSIZE = 32;
    localparam int NREQ  = 4;
    localparam int MAXB  = 4;
    localparam int IDW   = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid, req_last, req_ready;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  winc, wfull, awfull, busy;
    logic [DSIZE-1:0]      wdata;
    logic [IDW-1:0]        grant_id;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit bubble_en = 1'b0;

    typedef struct {
        int               id;
        logic [DSIZE-1:0] data;
        logic             bsy;
        int               cyc;
    } cap_t;

    cap_t             cap_q[$];
    logic [DSIZE:0]   srcq[NREQ][$];
    logic [DSIZE-1:0] sent_q[NREQ][$];

    async_fifo_wr_arbiter #(
        .DSIZE     (DSIZE),
        .NREQ      (NREQ),
        .MAX_BURST (MAXB),
        .IDW       (IDW)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .awfull    (awfull),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    // FIFO capture, source pops on accepted beats, and re-drive of source heads.
    always @(posedge wclk) begin
        logic [DSIZE:0] h;
        cyc++;
        if (winc === 1'b1) cap_q.push_back('{id: int'(grant_id), data: wdata, bsy: busy, cyc: cyc});
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0 && !(bubble_en && $urandom_range(0, 3) == 0)) begin
                h = srcq[i][0];
                req_valid[i] = 1'b1;
                req_data[i*DSIZE +: DSIZE] = h[DSIZE-1:0];
                req_last[i] = h[DSIZE];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DSIZE +: DSIZE] = $urandom;
                req_last[i] = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_beat(input int i, input logic [DSIZE-1:0] d, input logic l);
        srcq[i].push_back({l, d});
        sent_q[i].push_back(d);
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            srcq[i].delete();
            sent_q[i].delete();
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0; wfull = 1'b0; awfull = 1'b0; bubble_en = 1'b0;
        clear_src();
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        cap_q.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((any_pending() || busy === 1'b1) && n < budget) begin
            @(negedge wclk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin n_bad++; $display("FAIL %s_drain: got timeout after %0d cycles want drained", name, n); end
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; wfull = 1'b0; awfull = 1'b0;
        for (int i = 0; i < NREQ; i++) push_beat(i, DSIZE'(32'hC0 + i), 1'b1);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        n_cmp++; if (winc !== 1'b0) begin n_bad++; $display("FAIL rst_winc: got %b want 0", winc); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
        n_cmp++; if (wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", wdata); end
        clear_src();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        repeat (2) @(negedge wclk);
        n_cmp++; if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_bad++; $display("FAIL idle_outputs: got winc=%b ready=%b busy=%b gid=%0d want 0/0000/0/0", winc, req_ready, busy, grant_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_beat(i, DSIZE'(32'hA0 + i), 1'b1);
        wait_drain("rr", 100);
        n_cmp++; if (cap_q.size() != 8) begin n_bad++; $display("FAIL rr_count: got %0d want 8", cap_q.size()); end
        for (int k = 0; k < 8 && k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[k].data !== DSIZE'(32'hA0 + k % 4) || cap_q[k].cyc != cap_q[0].cyc + k) begin
                n_bad++; $display("FAIL rr_beat%0d: got %h@%0d want %h@%0d", k, cap_q[k].data, cap_q[k].cyc, 32'hA0 + k % 4, cap_q[0].cyc + k);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [DSIZE-1:0] ed[4] = '{32'h10, 32'h11, 32'h12, 32'h20};
        int               ei[4] = '{0, 0, 0, 1};
        logic             eb[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        push_beat(0, 32'h10, 1'b0); push_beat(0, 32'h11, 1'b0); push_beat(0, 32'h12, 1'b1);
        push_beat(1, 32'h20, 1'b1);
        wait_drain("lock", 100);
        n_cmp++; if (cap_q.size() != 4) begin n_bad++; $display("FAIL lock_count: got %0d want 4", cap_q.size()); end
        for (int k = 0; k < 4 && k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[k].data !== ed[k] || cap_q[k].id != ei[k] || cap_q[k].bsy !== eb[k] || cap_q[k].cyc != cap_q[0].cyc + k) begin
                n_bad++; $display("FAIL lock_beat%0d: got %h id%0d busy%b want %h id%0d busy%b contiguous", k, cap_q[k].data, cap_q[k].id, cap_q[k].bsy, ed[k], ei[k], eb[k]);
            end
        end
    endtask

    task automatic test_max_burst();
        logic [DSIZE-1:0] ed[7] = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h40, 32'h34, 32'h35};
        int               ei[7] = '{2, 2, 2, 2, 3, 2, 2};
        logic             eb[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int b = 0; b < 6; b++) push_beat(2, DSIZE'(32'h30 + b), (b == 5));
        push_beat(3, 32'h40, 1'b1);
        wait_drain("maxb", 100);
        n_cmp++; if (cap_q.size() != 7) begin n_bad++; $display("FAIL maxb_count: got %0d want 7", cap_q.size()); end
        for (int k = 0; k < 7 && k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[k].data !== ed[k] || cap_q[k].id != ei[k] || cap_q[k].bsy !== eb[k]) begin
                n_bad++; $display("FAIL maxb_beat%0d: got %h id%0d busy%b want %h id%0d busy%b", k, cap_q[k].data, cap_q[k].id, cap_q[k].bsy, ed[k], ei[k], eb[k]);
            end
        end
    endtask

    task automatic test_full();
        int n = 0;
        do_reset();
        awfull = 1'b1;
        push_beat(1, 32'h50, 1'b0); push_beat(1, 32'h51, 1'b0); push_beat(1, 32'h52, 1'b1);
        repeat (4) begin
            @(negedge wclk);
            n_cmp++; if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd1) begin
                n_bad++; $display("FAIL awfull_idle: got winc=%b ready=%b busy=%b gid=%0d want 0/0000/0/1", winc, req_ready, busy, grant_id);
            end
        end
        awfull = 1'b0;
        while (busy !== 1'b1 && n < 10) begin @(negedge wclk); n++; end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_start: got busy=%b want 1", busy); end
        awfull = 1'b1;
        #1;
        n_cmp++; if (winc !== 1'b1 || wdata !== 32'h51) begin n_bad++; $display("FAIL awfull_burst: got winc=%b wdata=%h want 1/51", winc, wdata); end
        wfull = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_bad++; $display("FAIL wfull_stall%0d: got winc=%b ready=%b busy=%b want 0/0000/1", c, winc, req_ready, busy);
            end
            @(negedge wclk);
        end
        wfull = 1'b0; awfull = 1'b0;
        wait_drain("full", 100);
        n_cmp++; if (cap_q.size() != 3) begin n_bad++; $display("FAIL full_count: got %0d want 3", cap_q.size()); end
        for (int k = 0; k < 3 && k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[k].data !== DSIZE'(32'h50 + k) || cap_q[k].id != 1) begin
                n_bad++; $display("FAIL full_beat%0d: got %h id%0d want %h id1", k, cap_q[k].data, cap_q[k].id, 32'h50 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DSIZE-1:0] ed[4] = '{32'h82, 32'h81, 32'h83, 32'h80};
        int n = 0;
        do_reset();
        for (int b = 0; b < 4; b++) push_beat(2, DSIZE'(32'h60 + b), (b == 3));
        while (cap_q.size() < 1 && n < 20) begin @(negedge wclk); n++; end
        n_cmp++; if (busy !== 1'b1 || winc !== 1'b1) begin n_bad++; $display("FAIL mid_beat2: got busy=%b winc=%b want 1/1", busy, winc); end
        wrst_n = 1'b0;
        #1;
        n_cmp++; if (winc !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0 || wdata !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset: got winc=%b busy=%b ready=%b gid=%0d wdata=%h want all zero", winc, busy, req_ready, grant_id, wdata);
        end
        clear_src();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        cap_q.delete();
        wrst_n = 1'b1;
        push_beat(3, 32'h80, 1'b1); push_beat(1, 32'h81, 1'b1);
        push_beat(0, 32'h82, 1'b1); push_beat(2, 32'h83, 1'b1);
        wait_drain("mid", 100);
        n_cmp++; if (cap_q.size() != 4) begin n_bad++; $display("FAIL mid_count: got %0d want 4", cap_q.size()); end
        for (int k = 0; k < 4 && k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[k].data !== ed[k]) begin n_bad++; $display("FAIL mid_order%0d: got %h want %h", k, cap_q[k].data, ed[k]); end
        end
    endtask

    task automatic test_random();
        int               m_ptr = 0, m_owner = 0, m_beats = 0, n = 0, g, cand;
        bit               m_busy = 1'b0, grant, e_winc, e_last;
        logic [NREQ-1:0]  e_ready;
        logic [DSIZE-1:0] e_wdata;
        int               got[$];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            int seq = 0;
            for (int p = 0; p < 4; p++) begin
                int len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    push_beat(i, {8'(i), 24'(seq)}, (b == len - 1));
                    seq++;
                end
            end
        end
        bubble_en = 1'b1;
        while (n < 3000) begin
            @(negedge wclk);
            if (!any_pending() && !m_busy) break;
            if (!m_busy) begin
                cand = -1;
                for (int k = 0; k < NREQ; k++)
                    if (cand < 0 && req_valid[(m_ptr + k) % NREQ]) cand = (m_ptr + k) % NREQ;
                g = (cand < 0) ? 0 : cand;
                grant = (cand >= 0) && !awfull && !wfull;
            end else begin
                g = m_owner;
                grant = 1'b1;
            end
            e_ready = (grant && !wfull) ? (NREQ'(1) << g) : '0;
            e_winc  = grant && !wfull && req_valid[g];
            e_wdata = grant ? req_data[g*DSIZE +: DSIZE] : '0;
            e_last  = req_last[g];
            n_cmp++; if (winc !== e_winc || req_ready !== e_ready || wdata !== e_wdata || grant_id !== IDW'(g) || busy !== m_busy) begin
                n_bad++; $display("FAIL rand_cyc%0d: got winc=%b ready=%b wdata=%h gid=%0d busy=%b want %b/%b/%h/%0d/%b",
                                  n, winc, req_ready, wdata, grant_id, busy, e_winc, e_ready, e_wdata, g, m_busy);
            end
            @(posedge wclk);
            if (e_winc) begin
                if (!m_busy) begin
                    if (e_last || MAXB == 1) m_ptr = (g + 1) % NREQ;
                    else begin m_busy = 1'b1; m_owner = g; m_beats = 1; end
                end else begin
                    m_beats++;
                    if (e_last || m_beats == MAXB) begin m_busy = 1'b0; m_ptr = (g + 1) % NREQ; end
                end
            end
            #2;
            wfull  = ($urandom_range(0, 3) == 0);
            awfull = ($urandom_range(0, 2) == 0);
            n++;
        end
        n_cmp++; if (n >= 3000) begin n_bad++; $display("FAIL rand_budget: got %0d cycles want completion", n); end
        wfull = 1'b0; awfull = 1'b0; bubble_en = 1'b0;
        wait_drain("rand", 200);
        for (int i = 0; i < NREQ; i++) begin
            got.delete();
            foreach (cap_q[k]) if (cap_q[k].id == i) got.push_back(int'(cap_q[k].data));
            n_cmp++; if (got.size() != sent_q[i].size()) begin n_bad++; $display("FAIL rand_req%0d_count: got %0d want %0d", i, got.size(), sent_q[i].size()); end
            for (int k = 0; k < got.size() && k < sent_q[i].size(); k++) begin
                n_cmp++; if (DSIZE'(got[k]) !== sent_q[i][k]) begin n_bad++; $display("FAIL rand_req%0d_beat%0d: got %h want %h", i, k, got[k], sent_q[i][k]); end
            end
        end
    endtask

    initial begin
        wrst_n = 1'b0; wfull = 1'b0; awfull = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_max_burst();
        test_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
